alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-issue stage that sits directly upstream of the 4-bit registered ALU. Accepts `{op, a, b}` commands on a valid/ready handshake and buffers them in a small FIFO. Issues one command per cycle onto the ALU's `inA`/`inB`/`op`/`en` inputs, and flags when the ALU's registered `ans` holds the matching result. Provides back-pressure upstream and a hold/flush control so the ALU is never enabled with stale operands.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `W`, 4: operand width; must match the ALU.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream command valid.
- `in_ready` out 1: stage can accept a command this cycle.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_op` in 2: opcode; 0 add, 1 sub, 2 and, 3 or.
- `hold` in 1: freeze issue; queue is kept.
- `flush` in 1: synchronous discard of all queued commands.
- `alu_a` out W: drives ALU `inA`.
- `alu_b` out W: drives ALU `inB`.
- `alu_op` out 2: drives ALU `op`.
- `alu_en` out 1: drives ALU `en`; high exactly one cycle per issued command.
- `res_valid` out 1: ALU `ans` holds the result of the command issued on the previous cycle.
- `count` out clog2(DEPTH)+1: current queue occupancy.

## Operation
- Storage is a circular FIFO with `rd_ptr`, `wr_ptr` and `count`. Pointers wrap modulo DEPTH.
- **Push** occurs when `in_valid && in_ready`. `in_ready = (count != DEPTH) && !flush`, decoded from registered `count`. A pop in the same cycle does not raise `in_ready` when the queue is full.
- **Pop/issue** occurs when state is RUN, `count != 0`, `!hold` and `!flush`. The head entry is registered into `alu_a`/`alu_b`/`alu_op` and `alu_en` is set to 1 for the next cycle.
- Push and pop in the same cycle leave `count` unchanged. A push into an empty queue cannot issue in the same cycle; the earliest issue is the following cycle.
- **FSM states:**
  - IDLE (`count == 0`) → RUN when `count` becomes nonzero.
  - RUN → HOLD when `hold` is high.
  - RUN → IDLE when the last entry pops and there is no push.
  - HOLD → RUN when `hold` is low and `count != 0`.
  - HOLD → IDLE when `hold` is low and `count == 0`.
- **flush** sets `count` to 0 and both pointers to 0, and forces the next state to IDLE. `alu_en` is 0 on the following cycle. A push in the flush cycle is dropped, because `in_ready = 0`. A `res_valid` already in flight still asserts.
- When no issue occurs, `alu_en` = 0 and `alu_a`/`alu_b`/`alu_op` hold their last values.
- `res_valid` is `alu_en` delayed by one register.
- Arithmetic is the ALU's business. This stage never modifies operand bits.

## Timing
- **Reset values:**
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `alu_en` = 0, `res_valid` = 0, `count` = 0.
  - `in_ready` = 1 after reset release.
  - State = IDLE; both pointers = 0.
- Asserting `rst_n` mid-operation discards the queue immediately and is asynchronous to `clk`.
- **Latency:**
  - Push at edge N gives the earliest `alu_en` high in cycle N+1.
  - The ALU captures at edge N+2.
  - `res_valid` is high in cycle N+2, aligned with the new `ans`.
- Back-to-back issue gives a sustained throughput of 1 command per cycle while `hold` is low.
- `hold` is sampled at the edge. If `hold` rises in cycle K, no issue takes place at edge K, and `alu_en` is 0 in cycle K+1.

## Configuration
- `ALU_CMD_ISSUER_STATS_EN`
- **Defined:** adds output `issued_cnt[7:0]`.
  - Increments on every issue and wraps 255→0.
  - Resets to 0 on `rst_n`.
  - Is not cleared by `flush`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `ALU_ADD=2'd0`, `ALU_SUB=2'd1`, `ALU_AND=2'd2`, `ALU_OR=2'd3`.
  - Command struct type `alu_cmd_t {op, a, b}`.
  - FSM state typedef `{IDLE, RUN, HOLD}`.
- One sub-module, `alu_cmd_fifo`, holds storage, pointers and `count`. The issue FSM and output registers stay in the top.

## Test plan
- **Reset:** drive `rst_n` = 0 mid-stream with 3 entries queued → `count` = 0, `alu_en` = 0 and `in_ready` = 1 immediately, with no clock required.
- **Single command:** push `{op=0, a=4'h7, b=4'h3}` at edge 0 → `alu_en` = 1 with `alu_a` = 7, `alu_b` = 3 in cycle 1; `res_valid` = 1 in cycle 2, and the ALU `ans` = 4'hA.
- **Fill to full under hold:**
  - Hold high, push 4 commands → `count` = 4 and `in_ready` = 0; a fifth `in_valid` is not accepted.
  - Release hold → 4 consecutive `alu_en` pulses in push order.
- **Wrap and simultaneous push/pop:** stream 10 commands with `in_valid` held high → one issue per cycle and `count` stays at 1. Commands appear in push order; sub with `a=2`, `b=5` yields `ans` = 4'hD.
- **Flush:** 3 queued, one in flight; assert `flush` → next cycle `count` = 0, `alu_en` = 0, and the in-flight `res_valid` still pulses. The push attempted during the flush cycle is not accepted.
- **Stats (macro defined):** issue 257 commands → `issued_cnt` = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-issue path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // Operand width of the downstream registered ALU.
    localparam int ALU_W = 4;

    // ALU opcodes.
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // One queued command: opcode and two operands.
    typedef struct packed {
        logic [1:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_cmd_t;

    // Issue FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

    // Flattened command width for a given operand width: {op, a, b}.
    function automatic int cmd_bits(input int w);
        return (2 * w) + 2;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command queue with occupancy count and synchronous flush.
// Latency: write visible at head one cycle after push; head read is combinational.
// Backpressure: none internally; caller must only push when count != DEPTH and pop when count != 0.
//
// Ports: clk/rst_n (async active-low); push/push_dat write side; pop advances head;
//        flush empties the queue (wins over push/pop); head_dat is the oldest entry;
//        count is the current occupancy (0..DEPTH).
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues {op,a,b} commands and issues one per cycle onto a registered 4-bit ALU.
// Latency: push at edge N -> alu_en in cycle N+1 -> res_valid with new ans in cycle N+2.
// Backpressure: in_ready low when the queue is full or during flush; hold freezes issue.
//
// Ports: in_valid/in_ready/in_a/in_b/in_op upstream command handshake;
//        hold freezes issue, flush discards the queue; alu_a/alu_b/alu_op/alu_en drive
//        the ALU; res_valid marks ALU ans valid; count is queue occupancy.
// Build option: define ALU_CMD_ISSUER_STATS_EN to add the issued_cnt[7:0] output
//        (wrapping issue counter, cleared only by reset).
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic [W-1:0]            in_b,
    input  logic [1:0]              in_op,
    input  logic                    hold,
    input  logic                    flush,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    output logic [1:0]              alu_op,
    output logic                    alu_en,
    output logic                    res_valid,
`ifdef ALU_CMD_ISSUER_STATS_EN
    output logic [7:0]              issued_cnt,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = cmd_bits(W);

    issue_state_t  state_q;
    issue_state_t  state_d;

    logic          push;
    logic          issue;
    logic [DW-1:0] push_dat;
    logic [DW-1:0] head_dat;
    logic [1:0]    head_op;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;
    logic [CW-1:0] pop_ext;
    logic          nonempty_nxt;

    // Ready is decoded from the registered count only, so a same-cycle pop
    // never opens a slot when the queue is full.
    assign in_ready = (count != CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign issue    = (state_q == RUN) && (count != '0) && !hold && !flush;
    assign push_dat = {in_op, in_a, in_b};

    assign head_op  = head_dat[DW-1 -: 2];
    assign head_a   = head_dat[2*W-1 -: W];
    assign head_b   = head_dat[W-1:0];

    // Queue will hold something after this edge: a push lands, or more
    // entries remain than the pop removes.
    assign pop_ext      = {{(CW-1){1'b0}}, issue};
    assign nonempty_nxt = push || (count > pop_ext);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (issue),
        .flush    (flush),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state looks at post-edge occupancy so a push into an empty queue
    // lands in RUN and can issue on the very next edge.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (nonempty_nxt) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (hold) begin
                        state_d = HOLD;
                    end else if (!nonempty_nxt) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        state_d = nonempty_nxt ? RUN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Operands only move on issue, so the ALU never sees a half-updated command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_en    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            alu_en    <= issue;
            res_valid <= alu_en;
            if (issue) begin
                alu_a  <= head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
            end
        end
    end

`ifdef ALU_CMD_ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= 8'd0;
        end else if (issue) begin
            issued_cnt <= issued_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic       hold;
    logic       flush;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_en;
    logic       res_valid;
    logic [2:0] count;
`ifdef ALU_CMD_ISSUER_STATS_EN
    logic [7:0] issued_cnt;
`endif

    logic [3:0] alu_ans;

    int checks = 0;
    int errors = 0;

    alu_cmd_t   cmdq[$];
    logic [3:0] ansq[$];
    alu_cmd_t   mon_cmd;

    alu_cmd_issuer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .hold       (hold),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .res_valid  (res_valid),
`ifdef ALU_CMD_ISSUER_STATS_EN
        .issued_cnt (issued_cnt),
`endif
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            default: return a | b;
        endcase
    endfunction

    // Stand-in for the downstream registered ALU.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ans <= 4'h0;
        end else if (alu_en) begin
            alu_ans <= alu_ref(alu_op, alu_a, alu_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic drive_rand();
        drive_cmd(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    task automatic wait_alu_en(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (alu_en) break;
        end
        chk("alu_en_wait", 32'(alu_en), 32'd1);
    endtask

    // Scoreboard: record accepted pushes, compare each issue and each result in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) begin
                if (ansq.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 32'd0);
                end else begin
                    chk("res_ans", 32'(alu_ans), 32'(ansq.pop_front()));
                end
            end
            if (alu_en) begin
                if (cmdq.size() == 0) begin
                    chk("issue_unexpected", 32'(alu_en), 32'd0);
                end else begin
                    mon_cmd = cmdq.pop_front();
                    chk("issue_a", 32'(alu_a), 32'(mon_cmd.a));
                    chk("issue_b", 32'(alu_b), 32'(mon_cmd.b));
                    chk("issue_op", 32'(alu_op), 32'(mon_cmd.op));
                    ansq.push_back(alu_ref(mon_cmd.op, mon_cmd.a, mon_cmd.b));
                end
            end
            if (flush) begin
                cmdq.delete();
            end else if (in_valid && in_ready) begin
                mon_cmd.op = in_op;
                mon_cmd.a  = in_a;
                mon_cmd.b  = in_b;
                cmdq.push_back(mon_cmd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_op    = '0;
        hold     = 1'b0;
        flush    = 1'b0;

        // Reset values
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single command: add 7 + 3
        step();
        drive_cmd(ALU_ADD, 4'h7, 4'h3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_c0_count", 32'(count), 32'd1);
        chk("single_c0_en", 32'(alu_en), 32'd0);
        @(negedge clk);
        chk("single_c1_en", 32'(alu_en), 32'd1);
        chk("single_c1_a", 32'(alu_a), 32'h7);
        chk("single_c1_b", 32'(alu_b), 32'h3);
        @(negedge clk);
        chk("single_c2_res_valid", 32'(res_valid), 32'd1);
        chk("single_c2_ans", 32'(alu_ans), 32'hA);

        // Fill to full under hold
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        drive_rand();
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_hold_en", 32'(alu_en), 32'd0);
        step();
        in_valid = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        chk("full_fifth_rejected", 32'(count), 32'd4);
        wait_alu_en(8);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("full_burst_en", 32'(alu_en), 32'd1);
        end
        @(negedge clk);
        chk("full_burst_end", 32'(alu_en), 32'd0);
        chk("full_drained", 32'(count), 32'd0);

        // Wrap and simultaneous push/pop: 10 back-to-back commands
        repeat (2) step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive_cmd(ALU_SUB, 4'h2, 4'h5);
            else        drive_rand();
            step();
            if (i == 9) in_valid = 1'b0;
            @(negedge clk);
            chk("stream_count", 32'(count), 32'd1);
            if (i > 0) chk("stream_en", 32'(alu_en), 32'd1);
            if (i == 5) chk("stream_sub_ans", 32'(alu_ans), 32'hD);
        end
        @(negedge clk);
        chk("stream_last_en", 32'(alu_en), 32'd1);
        chk("stream_end_count", 32'(count), 32'd0);

        // Flush with 3 queued and one in flight
        repeat (3) step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        step();
        step();
        flush = 1'b1;
        drive_rand();
        @(negedge clk);
        chk("flush_pre_en", 32'(alu_en), 32'd1);
        chk("flush_pre_count", 32'(count), 32'd3);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_en", 32'(alu_en), 32'd0);
        chk("flush_res_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        chk("flush_push_dropped", 32'(count), 32'd0);
        chk("flush_no_issue", 32'(alu_en), 32'd0);

        // Asynchronous reset mid-stream
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_alu_en", 32'(alu_en), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        cmdq.delete();
        ansq.delete();
        step();
        rst_n = 1'b1;
        step();

`ifdef ALU_CMD_ISSUER_STATS_EN
        // Issue counter wrap: 257 issues
        for (int i = 0; i < 257; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("stats_wrap", 32'(issued_cnt), 32'd1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_cmd_drained", 32'(cmdq.size()), 32'd0);
        chk("sb_ans_drained", 32'(ansq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
